rominit_stream: RTL and testbench

//  Synthesizable successor to the ROM-init byte feeder: accepts a byte download stream (e.g. from the
//  HPS/ioctl path), routes it to one of NUM_CH ROM targets (boot, chr, cart, ...) via one-hot

---
 rtl/rominit_stream.sv | 165 ++++++++++++++++
 tb/tb_rominit_stream.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rominit_stream.sv
// rominit_stream
//   Routes a byte download stream to one of NUM_CH ROM targets. Each download is
//   started with DL_START (which samples DL_INDEX and DL_PAD_TO). Bytes are
//   forwarded through a single output register with sequential addresses, and
//   downstream backpressure is honoured. If PAD_EN is set, a short image is padded
//   with PAD_VAL up to the requested length. A sticky per-channel LOADED flag is
//   set when the channel completes.
//
// Ports
//   CLK, RES       clock, synchronous active-high reset
//   DL_START       pulse: begin download (samples DL_INDEX, DL_PAD_TO)
//   DL_INDEX       target channel
//   DL_PAD_TO      minimum image length in bytes
//   DL_DATA        stream byte
//   DL_VALID       DL_DATA is valid
//   DL_READY       stream byte accepted when DL_VALID && DL_READY
//   DL_END         pulse: no more stream bytes
//   ROMINIT_SEL    one-hot target select, stable for the whole download
//   ROMINIT_ADDR   byte address
//   ROMINIT_DATA   byte
//   ROMINIT_VALID  ADDR/DATA valid
//   ROMINIT_READY  target consumes when VALID && READY
//   LOADED         sticky per-channel completion flags
//   BUSY           a download or its trailing gap is in progress
//   ERR            sticky: bad index or image overflow
module rominit_stream #(
    parameter int            NUM_CH  = 3,
    parameter int            AW      = 25,
    parameter int            DW      = 8,
    parameter int            PAD_EN  = 1,
    parameter logic [DW-1:0] PAD_VAL = 8'hFF,
    parameter int            GAP_CYC = 2,
    localparam int           IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              DL_START,
    input  logic [IW-1:0]     DL_INDEX,
    input  logic [AW:0]       DL_PAD_TO,
    input  logic [DW-1:0]     DL_DATA,
    input  logic              DL_VALID,
    output logic              DL_READY,
    input  logic              DL_END,
    output logic [NUM_CH-1:0] ROMINIT_SEL,
    output logic [AW-1:0]     ROMINIT_ADDR,
    output logic [DW-1:0]     ROMINIT_DATA,
    output logic              ROMINIT_VALID,
    input  logic              ROMINIT_READY,
    output logic [NUM_CH-1:0] LOADED,
    output logic              BUSY,
    output logic              ERR
);

    localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};
    localparam int          GW  = $clog2(GAP_CYC + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_PAD,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t        state;
    logic [AW:0]   cnt;
    logic [AW:0]   pad_to;
    logic [GW-1:0] gap_cnt;

    logic          out_free;
    logic          accept;
    logic [AW:0]   cnt_inc;
    logic [AW:0]   cnt_next;

    // Output register can take a new byte when empty or being drained this cycle.
    assign out_free = !ROMINIT_VALID || ROMINIT_READY;
    assign DL_READY = (state == S_STREAM) && out_free;
    assign accept   = DL_VALID && DL_READY;
    assign cnt_inc  = cnt + 1'b1;
    // Count after this cycle's byte; a byte arriving at full capacity is dropped.
    assign cnt_next = (accept && !cnt[AW]) ? cnt_inc : cnt;
    assign BUSY     = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state         <= S_IDLE;
            cnt           <= '0;
            pad_to        <= '0;
            gap_cnt       <= '0;
            ROMINIT_SEL   <= '0;
            ROMINIT_ADDR  <= '0;
            ROMINIT_DATA  <= '0;
            ROMINIT_VALID <= 1'b0;
            LOADED        <= '0;
            ERR           <= 1'b0;
        end else begin
            // Consumed entries retire unless a new byte is loaded below.
            if (ROMINIT_VALID && ROMINIT_READY)
                ROMINIT_VALID <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (DL_START) begin
                        if (int'(DL_INDEX) < NUM_CH) begin
                            cnt         <= '0;
                            pad_to      <= (DL_PAD_TO > CAP) ? CAP : DL_PAD_TO;
                            ROMINIT_SEL <= NUM_CH'(1) << DL_INDEX;
                            state       <= S_STREAM;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end

                S_STREAM: begin
                    if (accept) begin
                        if (cnt[AW]) begin
                            ERR <= 1'b1;
                        end else begin
                            ROMINIT_ADDR  <= cnt[AW-1:0];
                            ROMINIT_DATA  <= DL_DATA;
                            ROMINIT_VALID <= 1'b1;
                        end
                    end
                    cnt <= cnt_next;
                    if (DL_END)
                        state <= ((PAD_EN != 0) && (cnt_next < pad_to)) ? S_PAD : S_DRAIN;
                end

                // Only entered with cnt < pad_to <= CAP, so the address never wraps.
                S_PAD: begin
                    if (out_free) begin
                        ROMINIT_ADDR  <= cnt[AW-1:0];
                        ROMINIT_DATA  <= PAD_VAL;
                        ROMINIT_VALID <= 1'b1;
                        cnt           <= cnt_inc;
                        if (cnt_inc == pad_to)
                            state <= S_DRAIN;
                    end
                end

                // SEL is released only after the last byte has been consumed.
                S_DRAIN: begin
                    if (!ROMINIT_VALID) begin
                        LOADED      <= LOADED | ROMINIT_SEL;
                        ROMINIT_SEL <= '0;
                        gap_cnt     <= GW'(GAP_CYC);
                        state       <= S_GAP;
                    end
                end

                // GAP_CYC of 0 still spends a single cycle here.
                S_GAP: begin
                    if (gap_cnt <= GW'(1))
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rominit_stream.sv
module tb_rominit_stream;

    localparam int NUM_CH  = 3;
    localparam int AW      = 4;
    localparam int DW      = 8;
    localparam int GAP_CYC = 2;
    localparam int CAP     = 1 << AW;

    logic          CLK = 1'b0;
    logic          RES = 1'b1;
    logic          DL_START = 1'b0;
    logic [1:0]    DL_INDEX = '0;
    logic [AW:0]   DL_PAD_TO = '0;
    logic [DW-1:0] DL_DATA = '0;
    logic          DL_VALID = 1'b0;
    logic          DL_READY;
    logic          DL_END = 1'b0;
    logic [2:0]    ROMINIT_SEL;
    logic [AW-1:0] ROMINIT_ADDR;
    logic [DW-1:0] ROMINIT_DATA;
    logic          ROMINIT_VALID;
    logic          ROMINIT_READY = 1'b1;
    logic [2:0]    LOADED;
    logic          BUSY;
    logic          ERR;

    int checks = 0;
    int errors = 0;

    // Reference state: the image a download should leave in the target.
    int       img[$];
    int       exp_addr[$];
    int       exp_data[$];
    int       got_addr[$];
    int       got_data[$];
    logic [2:0] exp_sel = '0;
    logic [2:0] exp_loaded = '0;
    logic       exp_err = 1'b0;

    bit ready_rand  = 1'b0;
    bit ready_force = 1'b1;

    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;

    always #5 CLK = ~CLK;

    rominit_stream #(
        .NUM_CH (NUM_CH),
        .AW     (AW),
        .DW     (DW),
        .PAD_EN (1),
        .PAD_VAL(8'hFF),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .CLK          (CLK),
        .RES          (RES),
        .DL_START     (DL_START),
        .DL_INDEX     (DL_INDEX),
        .DL_PAD_TO    (DL_PAD_TO),
        .DL_DATA      (DL_DATA),
        .DL_VALID     (DL_VALID),
        .DL_READY     (DL_READY),
        .DL_END       (DL_END),
        .ROMINIT_SEL  (ROMINIT_SEL),
        .ROMINIT_ADDR (ROMINIT_ADDR),
        .ROMINIT_DATA (ROMINIT_DATA),
        .ROMINIT_VALID(ROMINIT_VALID),
        .ROMINIT_READY(ROMINIT_READY),
        .LOADED       (LOADED),
        .BUSY         (BUSY),
        .ERR          (ERR)
    );

    always @(posedge CLK) begin
        #1;
        ROMINIT_READY = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Target-side monitor: records consumed bytes, checks select and stall hold.
    always @(negedge CLK) begin
        if (RES) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (ROMINIT_VALID !== 1'b1 || ROMINIT_ADDR !== prev_addr || ROMINIT_DATA !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                             ROMINIT_VALID, ROMINIT_ADDR, ROMINIT_DATA, prev_addr, prev_data);
                end
            end
            if (ROMINIT_VALID === 1'b1) begin
                checks++;
                if (ROMINIT_SEL !== exp_sel) begin
                    errors++;
                    $display("FAIL sel_during_valid: got %b, required %b", ROMINIT_SEL, exp_sel);
                end
                if (ROMINIT_READY === 1'b1) begin
                    got_addr.push_back(int'(ROMINIT_ADDR));
                    got_data.push_back(int'(ROMINIT_DATA));
                end
            end
            prev_stall = (ROMINIT_VALID === 1'b1) && (ROMINIT_READY !== 1'b1);
            prev_addr  = ROMINIT_ADDR;
            prev_data  = ROMINIT_DATA;
        end
    end

    // Builds the image (base<0: random bytes) and the expected target contents.
    task automatic build_image(input int ch, input int n, input int pad_to, input int base);
        int lim;
        img.delete();
        exp_addr.delete();
        exp_data.delete();
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < n; i++)
            img.push_back(base < 0 ? int'($urandom_range(0, 255)) : ((base + i) & 255));
        for (int i = 0; i < n && i < CAP; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(img[i]);
        end
        lim = (pad_to > CAP) ? CAP : pad_to;
        for (int a = exp_addr.size(); a < lim; a++) begin
            exp_addr.push_back(a);
            exp_data.push_back(8'hFF);
        end
        exp_sel    = 3'(1 << ch);
        exp_loaded = exp_loaded | exp_sel;
        if (n > CAP) exp_err = 1'b1;
    endtask

    task automatic start_dl(input int ch, input int pad_to);
        @(posedge CLK); #1;
        DL_START  = 1'b1;
        DL_INDEX  = 2'(ch);
        DL_PAD_TO = (AW+1)'(pad_to);
        @(posedge CLK); #1;
        DL_START  = 1'b0;
    endtask

    task automatic send_bytes(input bit gaps);
        bit acc;
        int guard;
        for (int i = 0; i < img.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge CLK); #1;
            end
            DL_VALID = 1'b1;
            DL_DATA  = 8'(img[i]);
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 100) begin
                @(negedge CLK);
                acc = DL_READY;
                @(posedge CLK); #1;
                guard++;
            end
            DL_VALID = 1'b0;
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL byte_accept_timeout: byte %0d never accepted, required accept within 100 cycles", i);
            end
        end
        DL_END = 1'b1;
        @(posedge CLK); #1;
        DL_END = 1'b0;
    endtask

    // Waits for the gap after completion, then compares flags and image.
    task automatic finish_dl(input string name);
        int guard = 0;
        int n;
        do begin
            @(negedge CLK);
            guard++;
        end while (!(BUSY === 1'b1 && ROMINIT_SEL === 3'b000) && guard < 500);
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL %s_done_timeout: busy=%b sel=%b, required gap within 500 cycles", name, BUSY, ROMINIT_SEL);
        end
        checks++;
        if (LOADED !== exp_loaded) begin
            errors++;
            $display("FAIL %s_loaded: got %b, required %b", name, LOADED, exp_loaded);
        end
        checks++;
        if (ERR !== exp_err) begin
            errors++;
            $display("FAIL %s_err: got %b, required %b", name, ERR, exp_err);
        end
        for (int k = 1; k < GAP_CYC; k++) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b1) begin
                errors++;
                $display("FAIL %s_gap_busy: cycle %0d busy=%b, required 1", name, k, BUSY);
            end
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_busy: got %b, required 0", name, BUSY);
        end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes, required %0d", name, got_addr.size(), exp_addr.size());
        end
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                         name, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID, DL_READY, LOADED, BUSY, ERR} !== '0) begin
            errors++;
            $display("FAIL %s: sel=%b addr=%0d data=%h valid=%b dl_ready=%b loaded=%b busy=%b err=%b, required all 0",
                     name, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID, DL_READY, LOADED, BUSY, ERR);
        end
    endtask

    task automatic test_reset();
        RES = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset_state");
        RES = 1'b0;
        exp_loaded = '0;
        exp_err    = 1'b0;
    endtask

    task automatic test_basic();
        ready_force = 1'b1;
        build_image(1, 4, 0, 8'hA0);
        start_dl(1, 0);
        for (int i = 0; i < 4; i++) begin
            DL_VALID = 1'b1;
            DL_DATA  = 8'(img[i]);
            DL_END   = (i == 3);
            @(negedge CLK);
            checks++;
            if (DL_READY !== 1'b1) begin
                errors++;
                $display("FAIL basic_dl_ready%0d: got %b, required 1", i, DL_READY);
            end
            @(posedge CLK); #1;
            checks++;
            if (ROMINIT_VALID !== 1'b1 || ROMINIT_ADDR !== AW'(i) || ROMINIT_DATA !== 8'(8'hA0 + i)
                || ROMINIT_SEL !== 3'b010) begin
                errors++;
                $display("FAIL basic_latency%0d: valid=%b addr=%0d data=%h sel=%b, required 1 %0d %h 010",
                         i, ROMINIT_VALID, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_SEL, i, 8'hA0 + i);
            end
        end
        DL_VALID = 1'b0;
        DL_END   = 1'b0;
        finish_dl("basic");
    endtask

    task automatic test_backpressure();
        ready_force = 1'b1;
        build_image(0, 10, 0, -1);
        start_dl(0, 0);
        fork
            send_bytes(1'b0);
            begin
                repeat (4) @(negedge CLK);
                ready_force = 1'b0;
                repeat (3) begin
                    @(negedge CLK);
                    checks++;
                    if (DL_READY !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_dl_ready: got %b, required 0 while target stalls", DL_READY);
                    end
                end
                ready_force = 1'b1;
            end
        join
        finish_dl("backpressure");
    endtask

    task automatic test_pad();
        build_image(0, 5, 8, -1);
        start_dl(0, 8);
        send_bytes(1'b0);
        finish_dl("pad");
        build_image(2, 3, 20, -1);
        start_dl(2, 20);
        send_bytes(1'b0);
        finish_dl("pad_clamp");
    endtask

    task automatic test_random();
        int ch, n, pad;
        ready_rand = 1'b1;
        for (int t = 0; t < 6; t++) begin
            ch  = $urandom_range(0, 2);
            n   = $urandom_range(1, 12);
            pad = $urandom_range(0, 20);
            build_image(ch, n, pad, -1);
            start_dl(ch, pad);
            send_bytes(1'b1);
            finish_dl("random");
        end
        ready_rand  = 1'b0;
        ready_force = 1'b1;
    endtask

    task automatic test_reset_mid();
        build_image(1, 6, 0, -1);
        start_dl(1, 0);
        for (int i = 0; i < 3; i++) begin
            DL_VALID = 1'b1;
            DL_DATA  = 8'(img[i]);
            @(posedge CLK); #1;
        end
        DL_VALID = 1'b0;
        RES = 1'b1;
        @(posedge CLK); #1;
        check_reset_outputs("reset_mid");
        RES = 1'b0;
        exp_loaded = '0;
        exp_err    = 1'b0;
        build_image(1, 5, 0, -1);
        start_dl(1, 0);
        send_bytes(1'b0);
        finish_dl("after_reset");
    endtask

    task automatic test_overflow();
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pre_err: got %b, required 0", ERR);
        end
        build_image(0, CAP + 1, 0, -1);
        start_dl(0, 0);
        send_bytes(1'b0);
        finish_dl("overflow");
    endtask

    task automatic test_bad_index();
        @(posedge CLK); #1;
        DL_START = 1'b1;
        DL_INDEX = 2'd3;
        @(posedge CLK); #1;
        DL_START = 1'b0;
        exp_err  = 1'b1;
        checks++;
        if (ERR !== 1'b1 || BUSY !== 1'b0 || ROMINIT_SEL !== 3'b000) begin
            errors++;
            $display("FAIL bad_index: err=%b busy=%b sel=%b, required 1 0 000", ERR, BUSY, ROMINIT_SEL);
        end
        build_image(2, 4, 6, -1);
        start_dl(2, 6);
        send_bytes(1'b0);
        finish_dl("after_bad_index");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_pad();
        test_random();
        test_reset_mid();
        test_overflow();
        test_bad_index();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
